// File: rtl/ms_load_return_if.sv
// Bundle of the MS-stage handshake and data buses: the EX->MS instruction
// bus, the data-SRAM response, the WB flush/backpressure, and the MS->WB bus.
// The MS stage itself uses the slave view; the surrounding pipeline (or a
// bench) drives it through the master view.
interface ms_load_return_if;
   // EX -> MS
   logic        es2ms_valid;
   logic        ms_allowin;
   logic [31:0] es_pc;
   logic        es_gr_we;
   logic [4:0]  es_dest;
   logic [31:0] es_alu_result;
   logic        es_mem_req;
   logic [2:0]  es_ld_op;
   logic        es_ex;
   logic        es_req_orphan;
   // data SRAM response
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   // WB control
   logic        ws_allowin;
   logic        flush;
   // MS -> WB
   logic        ms2ws_valid;
   logic [31:0] ms_pc;
   logic        ms_gr_we;
   logic [4:0]  ms_dest;
   logic [31:0] ms_final_result;
   logic        ms_ex;
   logic        ms_ld_wait;

   modport slave (
      input  es2ms_valid, es_pc, es_gr_we, es_dest, es_alu_result,
             es_mem_req, es_ld_op, es_ex, es_req_orphan,
             data_sram_data_ok, data_sram_rdata, ws_allowin, flush,
      output ms_allowin, ms2ws_valid, ms_pc, ms_gr_we, ms_dest,
             ms_final_result, ms_ex, ms_ld_wait
   );

   modport master (
      output es2ms_valid, es_pc, es_gr_we, es_dest, es_alu_result,
             es_mem_req, es_ld_op, es_ex, es_req_orphan,
             data_sram_data_ok, data_sram_rdata, ws_allowin, flush,
      input  ms_allowin, ms2ws_valid, ms_pc, ms_gr_we, ms_dest,
             ms_final_result, ms_ex, ms_ld_wait
   );
endinterface

// File: rtl/ms_load_return.sv
// Memory-access stage between EX and WB. Holds one instruction, waits for
// its data-SRAM response, aligns/extends load data and hands the result to
// WB. Responses belonging to instructions killed by a WB flush are counted
// in cancel_cnt and silently dropped when they arrive.
module ms_load_return #(
   parameter int CANCEL_W = 2
) (
   input logic              clk,
   input logic              resetn,
   ms_load_return_if.slave  bus
);

   localparam logic [CANCEL_W:0] CNT_MAX = {1'b0, {CANCEL_W{1'b1}}};

   // ld_op encoding
   localparam logic [2:0] LD_W  = 3'd1;
   localparam logic [2:0] LD_B  = 3'd2;
   localparam logic [2:0] LD_BU = 3'd3;
   localparam logic [2:0] LD_H  = 3'd4;
   localparam logic [2:0] LD_HU = 3'd5;

   // Select the addressed byte/half of a word and extend it to 32 bits.
   function automatic logic [31:0] load_extend(input logic [2:0]  op,
                                                input logic [1:0]  addr,
                                                input logic [31:0] raw);
      logic [31:0]        sh_b;
      logic [31:0]        sh_h;
      logic signed [7:0]  b_s;
      logic signed [15:0] h_s;
      sh_b = raw >> {addr, 3'b000};
      sh_h = raw >> {addr[1], 4'b0000};
      b_s  = sh_b[7:0];
      h_s  = sh_h[15:0];
      case (op)
         LD_B:    load_extend = 32'(b_s);
         LD_BU:   load_extend = {24'h0, sh_b[7:0]};
         LD_H:    load_extend = 32'(h_s);
         LD_HU:   load_extend = {16'h0, sh_h[15:0]};
         LD_W:    load_extend = raw;
         default: load_extend = raw;
      endcase
   endfunction

   // Clamp the widened discard count to what the counter can hold.
   function automatic logic [CANCEL_W-1:0] sat_cnt(input logic [CANCEL_W:0] v);
      if (v > CNT_MAX) sat_cnt = CNT_MAX[CANCEL_W-1:0];
      else             sat_cnt = v[CANCEL_W-1:0];
   endfunction

   // control state
   logic                ms_valid_q, ms_valid_d;
   logic                pending_q, pending_d;
   logic                buf_valid_q, buf_valid_d;
   logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;
   // payload
   logic [31:0]         buf_q, buf_d;
   logic [31:0]         pc_q, pc_d;
   logic                gr_we_q, gr_we_d;
   logic [4:0]          dest_q, dest_d;
   logic [31:0]         alu_q, alu_d;
   logic [2:0]          ld_op_q, ld_op_d;
   logic                ex_q, ex_d;

   logic                cancel_nz;
   logic                stale_ok;
   logic                ms_ok;
   logic                kill_pending;
   logic                ready_go;
   logic                out_valid;
   logic                allowin;
   logic                out_fire;
   logic [CANCEL_W:0]   cnt_inc;
   logic [CANCEL_W:0]   cnt_dec;
   logic [CANCEL_W:0]   cnt_wide;
   logic [31:0]         raw_data;

   // Response routing, handshake and result selection.
   always_comb begin
      cancel_nz    = (cancel_cnt_q != '0);
      stale_ok     = bus.data_sram_data_ok & cancel_nz;
      ms_ok        = bus.data_sram_data_ok & ~cancel_nz & ms_valid_q & pending_q;
      // a pending request whose answer has not come back yet becomes stale
      kill_pending = ms_valid_q & pending_q & ~ms_ok;
      ready_go     = ~pending_q | (bus.data_sram_data_ok & ~cancel_nz) | buf_valid_q;
      out_valid    = ms_valid_q & ready_go & ~bus.flush;
      allowin      = ~ms_valid_q | (ready_go & bus.ws_allowin);
      out_fire     = out_valid & bus.ws_allowin;

      cnt_inc  = '0;
      if (bus.flush) begin
         cnt_inc = {{CANCEL_W{1'b0}}, kill_pending} + {{CANCEL_W{1'b0}}, bus.es_req_orphan};
      end
      cnt_dec  = {{CANCEL_W{1'b0}}, stale_ok};
      cnt_wide = {1'b0, cancel_cnt_q} + cnt_inc - cnt_dec;

      raw_data = buf_valid_q ? buf_q : bus.data_sram_rdata;

      bus.ms_allowin      = allowin;
      bus.ms2ws_valid     = out_valid;
      bus.ms_pc           = pc_q;
      bus.ms_gr_we        = gr_we_q;
      bus.ms_dest         = dest_q;
      bus.ms_ex           = ex_q;
      bus.ms_ld_wait      = ms_valid_q & (ld_op_q != 3'd0) & ~ready_go;
      bus.ms_final_result = ((ld_op_q == 3'd0) || ex_q) ? alu_q
                                                        : load_extend(ld_op_q, alu_q[1:0], raw_data);
   end

   // Next-state: capture/buffer response, accept from EX, flush.
   always_comb begin
      ms_valid_d   = ms_valid_q;
      pending_d    = pending_q;
      buf_valid_d  = buf_valid_q;
      buf_d        = buf_q;
      pc_d         = pc_q;
      gr_we_d      = gr_we_q;
      dest_d       = dest_q;
      alu_d        = alu_q;
      ld_op_d      = ld_op_q;
      ex_d         = ex_q;
      cancel_cnt_d = sat_cnt(cnt_wide);

      // WB stalled in the response cycle: park the data so it survives
      if (ms_ok && !bus.ws_allowin) begin
         buf_d       = bus.data_sram_rdata;
         buf_valid_d = 1'b1;
      end
      if (ms_ok) begin
         pending_d = 1'b0;
      end
      if (out_fire) begin
         buf_valid_d = 1'b0;
      end

      if (bus.flush) begin
         ms_valid_d  = 1'b0;
         pending_d   = 1'b0;
         buf_valid_d = 1'b0;
      end else if (allowin) begin
         ms_valid_d = bus.es2ms_valid;
         pending_d  = bus.es2ms_valid & bus.es_mem_req & ~bus.es_ex;
         if (bus.es2ms_valid) begin
            pc_d    = bus.es_pc;
            gr_we_d = bus.es_gr_we;
            dest_d  = bus.es_dest;
            alu_d   = bus.es_alu_result;
            ld_op_d = bus.es_ld_op;
            ex_d    = bus.es_ex;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid_q   <= 1'b0;
         pending_q    <= 1'b0;
         buf_valid_q  <= 1'b0;
         cancel_cnt_q <= '0;
         buf_q        <= '0;
         pc_q         <= '0;
         gr_we_q      <= 1'b0;
         dest_q       <= '0;
         alu_q        <= '0;
         ld_op_q      <= '0;
         ex_q         <= 1'b0;
      end else begin
         ms_valid_q   <= ms_valid_d;
         pending_q    <= pending_d;
         buf_valid_q  <= buf_valid_d;
         cancel_cnt_q <= cancel_cnt_d;
         buf_q        <= buf_d;
         pc_q         <= pc_d;
         gr_we_q      <= gr_we_d;
         dest_q       <= dest_d;
         alu_q        <= alu_d;
         ld_op_q      <= ld_op_d;
         ex_q         <= ex_d;
      end
   end

   // Protocol checks: discard counter overflow and unsolicited responses.
   always @(posedge clk) begin
      if (resetn) begin
         assert (!(bus.flush && (cnt_wide > CNT_MAX)))
            else $error("ms_load_return: cancel counter overflow");
         assert (!(bus.data_sram_data_ok && !cancel_nz && !(ms_valid_q && pending_q)))
            else $error("ms_load_return: data_ok with nothing outstanding");
      end
   end

endmodule

// File: tb/tb_ms_load_return.sv
// Directed bench for ms_load_return: stimulus pushes the expected WB
// transfer into a scoreboard queue, a monitor pops and compares on every
// ms2ws_valid & ws_allowin cycle; timing details are checked inline.
module tb_ms_load_return;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   ms_load_return_if bus();

   ms_load_return #(.CANCEL_W(2)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] res;
      logic        ex;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_act;
   exp_t mon_exp;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.es2ms_valid       = 1'b0;
      bus.es_pc             = '0;
      bus.es_gr_we          = 1'b0;
      bus.es_dest           = '0;
      bus.es_alu_result     = '0;
      bus.es_mem_req        = 1'b0;
      bus.es_ld_op          = '0;
      bus.es_ex             = 1'b0;
      bus.es_req_orphan     = 1'b0;
      bus.data_sram_data_ok = 1'b0;
      bus.data_sram_rdata   = '0;
      bus.ws_allowin        = 1'b1;
      bus.flush             = 1'b0;
   endtask

   // Present one instruction until MS accepts it; optionally expect it at WB.
   task automatic issue(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                        input logic [31:0] alu, input logic mem, input logic [2:0] op,
                        input logic ex, input logic expect_out, input logic [31:0] res);
      bus.es2ms_valid   = 1'b1;
      bus.es_pc         = pc;
      bus.es_gr_we      = we;
      bus.es_dest       = dest;
      bus.es_alu_result = alu;
      bus.es_mem_req    = mem;
      bus.es_ld_op      = op;
      bus.es_ex         = ex;
      for (int n = 0; n <= 20; n++) begin
         @(negedge clk);
         if (bus.ms_allowin) break;
         if (n == 20) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: pc 0x%08h never accepted, expected acceptance", pc);
         end
      end
      if (expect_out) exp_q.push_back({pc, we, dest, res, ex});
      cyc();
      bus.es2ms_valid = 1'b0;
      bus.es_mem_req  = 1'b0;
      bus.es_ld_op    = '0;
      bus.es_ex       = 1'b0;
   endtask

   // Scoreboard monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (resetn && bus.ms2ws_valid && bus.ws_allowin) begin
            mon_act = {bus.ms_pc, bus.ms_gr_we, bus.ms_dest, bus.ms_final_result, bus.ms_ex};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out: pc 0x%08h result 0x%08h, expected no transfer",
                        bus.ms_pc, bus.ms_final_result);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_act !== mon_exp) begin
                  errors++;
                  $display("FAIL wb_transfer: got pc 0x%08h we %b dest %0d res 0x%08h ex %b, expected pc 0x%08h we %b dest %0d res 0x%08h ex %b",
                           mon_act.pc, mon_act.gr_we, mon_act.dest, mon_act.res, mon_act.ex,
                           mon_exp.pc, mon_exp.gr_we, mon_exp.dest, mon_exp.res, mon_exp.ex);
               end
            end
         end
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   // Stimulus.
   initial begin
      idle_inputs();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      chk1("rst_allowin", bus.ms_allowin, 1'b1);
      chk1("rst_valid",   bus.ms2ws_valid, 1'b0);
      chk1("rst_ldwait",  bus.ms_ld_wait, 1'b0);
      chk ("rst_pc",      bus.ms_pc, 32'h0);
      chk ("rst_result",  bus.ms_final_result, 32'h0);
      cyc();
      resetn = 1'b1;

      // T5: four ALU ops back to back, one per cycle
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            bus.es2ms_valid   = 1'b1;
            bus.es_pc         = 32'h100 + 32'(4 * i);
            bus.es_gr_we      = 1'b1;
            bus.es_dest       = 5'(i + 1);
            bus.es_alu_result = 32'h1111_1111 * 32'(i + 1);
         end else begin
            bus.es2ms_valid = 1'b0;
         end
         @(negedge clk);
         if (i > 0) begin
            chk1("t5_valid",  bus.ms2ws_valid, 1'b1);
            chk1("t5_ldwait", bus.ms_ld_wait, 1'b0);
         end
         if (i < 4) begin
            chk1("t5_allowin", bus.ms_allowin, 1'b1);
            exp_q.push_back({32'h100 + 32'(4 * i), 1'b1, 5'(i + 1),
                             32'h1111_1111 * 32'(i + 1), 1'b0});
         end
         cyc();
      end
      @(negedge clk);
      chk1("t5_idle", bus.ms2ws_valid, 1'b0);
      cyc();

      // T1: LD.B at byte 3, response two cycles after acceptance
      issue(32'h200, 1'b1, 5'd5, 32'h0000_1003, 1'b1, 3'd2, 1'b0, 1'b1, 32'hFFFF_FF80);
      @(negedge clk);
      chk1("t1_wait_valid", bus.ms2ws_valid, 1'b0);
      chk1("t1_ldwait",     bus.ms_ld_wait, 1'b1);
      chk1("t1_allowin",    bus.ms_allowin, 1'b0);
      cyc();
      cyc();
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = 32'h80FF_0000;
      @(negedge clk);
      chk1("t1_out_valid", bus.ms2ws_valid, 1'b1);
      chk ("t1_result",    bus.ms_final_result, 32'hFFFF_FF80);
      cyc();
      bus.data_sram_data_ok = 1'b0;
      @(negedge clk);
      chk1("t1_drained", bus.ms2ws_valid, 1'b0);
      cyc();

      // T2: LD.HU at half 1, WB stalls three cycles from the response
      issue(32'h300, 1'b1, 5'd6, 32'h0000_2002, 1'b1, 3'd5, 1'b0, 1'b1, 32'h0000_80FF);
      bus.ws_allowin        = 1'b0;
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = 32'h80FF_1234;
      @(negedge clk);
      chk1("t2_ready", bus.ms2ws_valid, 1'b1);
      cyc();
      bus.data_sram_data_ok = 1'b0;
      bus.data_sram_rdata   = 32'h0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk1("t2_hold_valid", bus.ms2ws_valid, 1'b1);
         chk ("t2_buf_result", bus.ms_final_result, 32'h0000_80FF);
         chk1("t2_ldwait",     bus.ms_ld_wait, 1'b0);
         cyc();
      end
      bus.ws_allowin = 1'b1;
      @(negedge clk);
      chk1("t2_release", bus.ms2ws_valid, 1'b1);
      cyc();
      @(negedge clk);
      chk1("t2_gone", bus.ms2ws_valid, 1'b0);
      cyc();

      // T3: flush with pending load plus orphan request -> two stale responses
      issue(32'h400, 1'b1, 5'd7, 32'h0000_3000, 1'b1, 3'd1, 1'b0, 1'b0, 32'h0);
      bus.flush         = 1'b1;
      bus.es_req_orphan = 1'b1;
      @(negedge clk);
      chk1("t3_flush_valid", bus.ms2ws_valid, 1'b0);
      cyc();
      bus.flush         = 1'b0;
      bus.es_req_orphan = 1'b0;
      issue(32'h500, 1'b1, 5'd8, 32'h0000_3004, 1'b1, 3'd1, 1'b0, 1'b1, 32'hCAFE_F00D);
      for (int i = 0; i < 2; i++) begin
         bus.data_sram_data_ok = 1'b1;
         bus.data_sram_rdata   = (i == 0) ? 32'h1111_1111 : 32'h2222_2222;
         @(negedge clk);
         chk1("t3_stale_valid",  bus.ms2ws_valid, 1'b0);
         chk1("t3_stale_ldwait", bus.ms_ld_wait, 1'b1);
         cyc();
      end
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = 32'hCAFE_F00D;
      @(negedge clk);
      chk1("t3_third_valid", bus.ms2ws_valid, 1'b1);
      cyc();
      bus.data_sram_data_ok = 1'b0;

      // T4: flush in the same cycle as MS's own response -> nothing to discard
      issue(32'h600, 1'b1, 5'd9, 32'h0000_5000, 1'b1, 3'd1, 1'b0, 1'b0, 32'h0);
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = 32'hDEAD_0000;
      bus.flush             = 1'b1;
      @(negedge clk);
      chk1("t4_flush_valid", bus.ms2ws_valid, 1'b0);
      cyc();
      bus.data_sram_data_ok = 1'b0;
      bus.flush             = 1'b0;
      issue(32'h700, 1'b1, 5'd10, 32'h0000_4002, 1'b1, 3'd4, 1'b0, 1'b1, 32'hFFFF_8001);
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = 32'h8001_0000;
      @(negedge clk);
      chk1("t4_next_valid", bus.ms2ws_valid, 1'b1);
      chk ("t4_result",     bus.ms_final_result, 32'hFFFF_8001);
      cyc();
      bus.data_sram_data_ok = 1'b0;

      // Exception-carrying load: no wait, result is the ALU value
      issue(32'h780, 1'b1, 5'd11, 32'hBADA_DD12, 1'b1, 3'd1, 1'b1, 1'b1, 32'hBADA_DD12);
      @(negedge clk);
      chk1("t7_valid",  bus.ms2ws_valid, 1'b1);
      chk1("t7_ldwait", bus.ms_ld_wait, 1'b0);
      cyc();

      // T6: asynchronous reset while a load is pending
      issue(32'h800, 1'b1, 5'd12, 32'h0000_6000, 1'b1, 3'd1, 1'b0, 1'b0, 32'h0);
      #2;
      resetn = 1'b0;
      #1;
      chk1("t6_allowin", bus.ms_allowin, 1'b1);
      chk1("t6_valid",   bus.ms2ws_valid, 1'b0);
      chk1("t6_ldwait",  bus.ms_ld_wait, 1'b0);
      chk ("t6_pc",      bus.ms_pc, 32'h0);
      chk ("t6_result",  bus.ms_final_result, 32'h0);
      cyc();
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = 32'h1234_5678;
      @(negedge clk);
      chk1("t6_ignored_valid",   bus.ms2ws_valid, 1'b0);
      chk1("t6_ignored_allowin", bus.ms_allowin, 1'b1);
      cyc();
      bus.data_sram_data_ok = 1'b0;
      cyc();
      resetn = 1'b1;
      @(negedge clk);
      chk1("t6_post_valid", bus.ms2ws_valid, 1'b0);
      cyc();
      issue(32'h900, 1'b1, 5'd13, 32'h1357_2468, 1'b0, 3'd0, 1'b0, 1'b1, 32'h1357_2468);
      @(negedge clk);
      chk1("t6_add_valid", bus.ms2ws_valid, 1'b1);
      cyc();

      repeat (3) cyc();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d transfers outstanding, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
